// File: rtl/sr_simd_exu.sv
// Packed-SIMD execution unit: per-lane add, subtract, shift-add multiply and unsigned max.
// Define SR_SIMD_EXU_SAT_EN to make the lanes saturate instead of wrapping.
module sr_simd_exu #(
   parameter int XLEN   = 32,
   parameter int LANE_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] a_bi,
   input  logic [XLEN-1:0] b_bi,
   output logic            busy_o,
   output logic            valid_o,
   output logic [XLEN-1:0] out
);

   localparam int LANES = XLEN / LANE_W;
   localparam int CW    = $clog2(LANE_W + 1);

   localparam logic [1:0] OP_PADD  = 2'b00;
   localparam logic [1:0] OP_PSUB  = 2'b01;
   localparam logic [1:0] OP_PMUL  = 2'b10;
   localparam logic [1:0] OP_PMAXU = 2'b11;

   if (XLEN % LANE_W != 0) begin : g_bad_cfg
      $error("sr_simd_exu: XLEN must be an integer multiple of LANE_W");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                            state_q, state_d;
   logic [XLEN-1:0]                   a_q, a_d;
   logic [1:0]                        op_q, op_d;
   logic [CW-1:0]                     cnt_q, cnt_d;
   logic [LANES-1:0][2*LANE_W-1:0]    acc_q, acc_d, acc_step;
   logic [XLEN-1:0]                   out_q, out_d;
   logic [LANES-1:0][LANE_W-1:0]      alu_res, mul_res;

   // Accumulator holds {partial product, remaining multiplier bits}; each step adds and shifts right.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [LANE_W-1:0] la, lb, lane_res;
      logic [LANE_W:0]   mac;
`ifdef SR_SIMD_EXU_SAT_EN
      logic [LANE_W:0]   sum, dif;
`else
      logic [LANE_W-1:0] sum, dif;
`endif

      assign la  = a_bi[k*LANE_W +: LANE_W];
      assign lb  = b_bi[k*LANE_W +: LANE_W];
      assign sum = {1'b0, la} + {1'b0, lb};
      assign dif = {1'b0, la} - {1'b0, lb};
      assign mac = {1'b0, acc_q[k][2*LANE_W-1:LANE_W]}
                 + (acc_q[k][0] ? {1'b0, a_q[k*LANE_W +: LANE_W]} : '0);
      assign acc_step[k] = {mac, acc_q[k][LANE_W-1:1]};

      always_comb begin
         case (op_i)
`ifdef SR_SIMD_EXU_SAT_EN
            OP_PADD:  lane_res = sum[LANE_W] ? '1 : sum[LANE_W-1:0];
            OP_PSUB:  lane_res = dif[LANE_W] ? '0 : dif[LANE_W-1:0];
`else
            OP_PADD:  lane_res = sum;
            OP_PSUB:  lane_res = dif;
`endif
            OP_PMAXU: lane_res = (la >= lb) ? la : lb;
            default:  lane_res = '0;
         endcase
      end

      assign alu_res[k] = lane_res;
`ifdef SR_SIMD_EXU_SAT_EN
      assign mul_res[k] = (|acc_step[k][2*LANE_W-1:LANE_W]) ? '1 : acc_step[k][LANE_W-1:0];
`else
      assign mul_res[k] = acc_step[k][LANE_W-1:0];
`endif
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      out_d   = out_q;
      busy_o  = 1'b0;
      valid_o = 1'b0;
      case (state_q)
         IDLE: begin
            busy_o = start_i;
            if (start_i) begin
               a_d  = a_bi;
               op_d = op_i;
               if (op_i == OP_PMUL) begin
                  state_d = RUN;
                  cnt_d   = CW'(LANE_W);
                  for (int k = 0; k < LANES; k++) begin
                     acc_d[k] = {{LANE_W{1'b0}}, b_bi[k*LANE_W +: LANE_W]};
                  end
               end else begin
                  state_d = DONE;
                  out_d   = alu_res;
               end
            end
         end
         RUN: begin
            busy_o = 1'b1;
            if (op_q == OP_PMUL) begin
               acc_d = acc_step;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d = DONE;
                  out_d   = mul_res;
               end
            end else begin
               state_d = IDLE;
            end
         end
         DONE: begin
            valid_o = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: tb/tb_sr_simd_exu.sv
// Self-checking bench for sr_simd_exu (XLEN=32, LANE_W=8): vector table, scoreboard queue,
// back-to-back and mid-multiply reset sequences.
module tb_sr_simd_exu;

`ifdef SR_SIMD_EXU_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   localparam logic [1:0] PADD = 2'b00, PSUB = 2'b01, PMUL = 2'b10, PMAXU = 2'b11;

   logic        clk, rst_n, start_i, busy_o, valid_o;
   logic [1:0]  op_i;
   logic [31:0] a_bi, b_bi, out;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [31:0] out;
      int          lat;
   } exp_t;

   vec_t vecs[$];
   exp_t expQ[$];
   int   nVec = 0;
   int   nMis = 0;

   sr_simd_exu #(.XLEN(32), .LANE_W(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (start_i),
      .op_i    (op_i),
      .a_bi    (a_bi),
      .b_bi    (b_bi),
      .busy_o  (busy_o),
      .valid_o (valid_o),
      .out     (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference lane model written with plain integer arithmetic.
   function automatic logic [31:0] modelOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      int x, y, v;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         x = int'(a[k*8 +: 8]);
         y = int'(b[k*8 +: 8]);
         case (op)
            PADD:    begin v = x + y; if (v > 255) v = SAT ? 255 : v - 256; end
            PSUB:    begin v = x - y; if (v < 0)   v = SAT ? 0 : v + 256; end
            PMUL:    begin v = x * y; if (v > 255) v = SAT ? 255 : v % 256; end
            default: v = (x >= y) ? x : y;
         endcase
         r[k*8 +: 8] = v[7:0];
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nMis++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Drives one instruction; with b2b the inputs change during DONE and the start cycle is the next one.
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp, input bit b2b);
      exp_t e;
      bit   seen;
      start_i = 1'b1;
      op_i    = op;
      a_bi    = a;
      b_bi    = b;
      e.out   = exp;
      e.lat   = (op == PMUL) ? 9 : 1;
      expQ.push_back(e);
      if (b2b) @(negedge clk);
      #1;
      checkOutput("busy_start", {31'b0, busy_o}, 32'd1);
      checkOutput("valid_start", {31'b0, valid_o}, 32'd0);
      seen = 1'b0;
      for (int c = 1; c <= 20 && !seen; c++) begin
         @(negedge clk);
         if (valid_o) begin
            seen = 1'b1;
            if (expQ.size() == 0) begin
               checkOutput("unexpected_valid", 32'd1, 32'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("result", out, e.out);
               checkOutput("latency", c, e.lat);
            end
            checkOutput("busy_done", {31'b0, busy_o}, 32'd0);
         end else begin
            checkOutput("busy_run", {31'b0, busy_o}, 32'd1);
         end
      end
      if (!seen) checkOutput("valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic idleCycle(input logic [31:0] lastOut);
      start_i = 1'b0;
      @(negedge clk);
      checkOutput("idle_valid", {31'b0, valid_o}, 32'd0);
      checkOutput("idle_busy", {31'b0, busy_o}, 32'd0);
      checkOutput("out_hold", out, lastOut);
   endtask

   initial begin
      vec_t v;
      logic [31:0] ra, rb;

      vecs.push_back('{PADD,  32'h01FF7F80, 32'h01010101, SAT ? 32'h02FF8081 : 32'h02008081});
      vecs.push_back('{PSUB,  32'h10000510, 32'h01010101, SAT ? 32'h0F00040F : 32'h0FFF040F});
      vecs.push_back('{PMUL,  32'h02030410, 32'h03050611, SAT ? 32'h060F18FF : 32'h060F1810});
      vecs.push_back('{PMAXU, 32'h80017F02, 32'h7F02807F, 32'h8002807F});
      vecs.push_back('{PADD,  32'hFFFFFFFF, 32'h01FF0080, modelOp(PADD,  32'hFFFFFFFF, 32'h01FF0080)});
      vecs.push_back('{PSUB,  32'h00FF8001, 32'hFF01807F, modelOp(PSUB,  32'h00FF8001, 32'hFF01807F)});
      vecs.push_back('{PMUL,  32'hFF0F1001, 32'hFF11100F, modelOp(PMUL,  32'hFF0F1001, 32'hFF11100F)});
      vecs.push_back('{PMAXU, 32'h55AA00FF, 32'h55AB01FE, modelOp(PMAXU, 32'h55AA00FF, 32'h55AB01FE)});
      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = $urandom;
         vecs.push_back('{i[1:0], ra, rb, modelOp(i[1:0], ra, rb)});
      end

      rst_n   = 1'b0;
      start_i = 1'b0;
      op_i    = PADD;
      a_bi    = '0;
      b_bi    = '0;
      #3;
      checkOutput("reset_out", out, 32'd0);
      checkOutput("reset_valid", {31'b0, valid_o}, 32'd0);
      checkOutput("reset_busy_lo", {31'b0, busy_o}, 32'd0);
      start_i = 1'b1;
      #1;
      checkOutput("reset_busy_hi", {31'b0, busy_o}, 32'd1);
      start_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         v = vecs[i];
         applyStimulus(v.op, v.a, v.b, v.exp, 1'b0);
         idleCycle(v.exp);
         idleCycle(v.exp);
      end

      // PMAXU immediately followed by PADD while start_i stays high.
      applyStimulus(PMAXU, 32'h80017F02, 32'h7F02807F, 32'h8002807F, 1'b0);
      applyStimulus(PADD, 32'h01010101, 32'h01010101, 32'h02020202, 1'b1);
      idleCycle(32'h02020202);

      // Reset during the fourth RUN cycle of a multiply.
      start_i = 1'b1;
      op_i    = PMUL;
      a_bi    = 32'h02030410;
      b_bi    = 32'h03050611;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midrun_out", out, 32'd0);
      checkOutput("midrun_valid", {31'b0, valid_o}, 32'd0);
      checkOutput("midrun_busy_hi", {31'b0, busy_o}, 32'd1);
      start_i = 1'b0;
      #1;
      checkOutput("midrun_busy_lo", {31'b0, busy_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         checkOutput("no_valid_after_abort", {31'b0, valid_o}, 32'd0);
      end
      applyStimulus(PMUL, 32'h02030410, 32'h03050611, SAT ? 32'h060F18FF : 32'h060F1810, 1'b0);
      idleCycle(SAT ? 32'h060F18FF : 32'h060F1810);

      checkOutput("scoreboard_empty", expQ.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule

// File: doc/sr_simd_exu.md
SR_SIMD_EXU -- requirements
Module: sr_simd_exu

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits.
REQ-002 Parameter LANE_W, default 8, lane width in bits; XLEN SHALL be an integer multiple of LANE_W, else elaboration SHALL fail.
REQ-003 Derived LANES = XLEN/LANE_W; lane k SHALL occupy bits [k*LANE_W +: LANE_W].
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start_i  input  1  operation request; held high by the core for the whole instruction.
REQ-007 op_i  input  2  opcode: 00 PADD, 01 PSUB, 10 PMUL, 11 PMAXU.
REQ-008 a_bi  input  XLEN  operand A.
REQ-009 b_bi  input  XLEN  operand B.
REQ-010 busy_o  output  1  stall request to the core's PC register.
REQ-011 valid_o  output  1  result valid; the core writes back in this cycle.
REQ-012 out  output  XLEN  packed result.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-014 busy_o SHALL be combinational: (IDLE and start_i) or RUN.
REQ-015 valid_o SHALL be 1 exactly in DONE.
REQ-016 In IDLE with start_i=1, the block SHALL latch a_bi, b_bi and op_i.
REQ-017 On that start, PADD, PSUB and PMAXU SHALL register the result into out and go to DONE: 1-cycle latency.
REQ-018 On that start, PMUL SHALL go to RUN and load the lane counter with LANE_W.
REQ-019 In RUN, PMUL SHALL do one shift-add step per cycle in every lane in parallel, unsigned, with a 2*LANE_W-bit accumulator per lane.
REQ-020 After LANE_W RUN cycles, PMUL SHALL go to DONE with out updated: valid_o at cycle LANE_W+1 after the start cycle.
REQ-021 DONE SHALL go to IDLE unconditionally, ignoring start_i, so a held start_i never re-triggers.
REQ-022 start_i SHALL be ignored in RUN and DONE.
REQ-023 start_i asserted in IDLE directly after DONE SHALL start a new operation (back-to-back instructions).
REQ-024 out SHALL hold its last value outside DONE until the next operation completes.
REQ-025 Lanes SHALL be independent: no carry, borrow or product bits cross a lane boundary.
REQ-026 PADD and PSUB SHALL be unsigned modulo 2^LANE_W per lane (see REQ-032 for the saturating variant).
REQ-027 PMUL SHALL return the low LANE_W bits of each lane product.
REQ-028 PMAXU SHALL return the unsigned per-lane maximum; on a tie, that lane of A.
REQ-029 An undefined state SHALL recover to IDLE.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, out 0, valid_o 0, counter 0 and accumulators 0; busy_o SHALL then equal start_i.
REQ-031 Reset asserted mid-RUN SHALL abort the PMUL with no valid_o pulse; after release, the next start SHALL behave as a fresh operation.

Configuration
REQ-032 Macro SR_SIMD_EXU_SAT_EN defined: lanes SHALL saturate instead of wrap.
  - PADD overflow -> all-ones.
  - PSUB underflow -> 0.
  - PMUL with a nonzero high product half -> all-ones.
  - PMAXU is unaffected.
REQ-033 Macro SR_SIMD_EXU_SAT_EN undefined: wrap-around per REQ-026/REQ-027, and no saturation logic SHALL be synthesised.

Verification (XLEN=32, LANE_W=8)
REQ-034 PADD A=0x01FF7F80, B=0x01010101:
  - busy_o high 1 cycle.
  - Next cycle valid_o=1 and out=0x02008081 (SAT_EN: 0x02FF8081).
REQ-035 PSUB A=0x10000510, B=0x01010101 -> out=0x0FFF040F (SAT_EN: 0x0F00040F).
REQ-036 PMUL A=0x02030410, B=0x03050611, start_i held 10 cycles:
  - busy_o high cycles 0-8.
  - valid_o only in cycle 9, out=0x060F1810 (SAT_EN: 0x060F18FF).
  - No second start.
REQ-037 PMAXU A=0x80017F02, B=0x7F02807F -> out=0x8002807F, then back-to-back PADD A=B=0x01010101 -> out=0x02020202.
REQ-038 PMUL started, rst_n pulsed low in RUN cycle 4:
  - out=0, valid_o=0 and busy_o=start_i immediately.
  - No valid_o pulse follows.
  - A new PMUL after release completes in 9 cycles.
